// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture sequencer.
//   - state_t          : capture sequencer states
//   - CH_A / CH_B      : channel tag carried in the top bit of each output beat
//   - tdata_*_idx()    : bit positions of the tag fields inside m_axis_tdata
//   - pair_*()         : field layout of one {or, a, b} entry in the pair FIFO
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_ABORT   = 2'd3
  } state_t;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Output beat: {channel, overrange, sample[dw-1:0]}
  function automatic int unsigned tdata_ch_idx(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned tdata_or_idx(input int unsigned dw);
    return dw;
  endfunction

  // Pair FIFO entry: {overrange, sample_a, sample_b}
  function automatic int unsigned pair_or_idx(input int unsigned dw);
    return 2 * dw;
  endfunction

  function automatic int unsigned pair_a_lsb(input int unsigned dw);
    return dw;
  endfunction

endpackage

// File: rtl/adc_pair_fifo.sv
// Synchronous FIFO holding captured {or, a, b} sample pairs.
// First-word fall-through: o_rd_data_c shows the head entry whenever not empty.
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
// Ports:
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_flush            : empties the FIFO on the next edge (write ignored)
//   i_wr_en, i_wr_data : push, ignored when full
//   i_rd_en            : pop, ignored when empty
//   o_rd_data_c        : head entry
//   o_full_c, o_empty_c: occupancy flags
module adc_pair_fifo #(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data_c,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr;
  logic             w_rd;

  assign o_full_c    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty_c   = (r_wr_ptr == r_rd_ptr);
  assign o_rd_data_c = r_mem[r_rd_ptr[AW-1:0]];
  assign w_wr        = i_wr_en && !o_full_c && !i_flush;
  assign w_rd        = i_rd_en && !o_empty_c && !i_flush;

  // Pointer update
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage, no reset needed: contents only read when not empty
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer between the ADC deserializer and an AXI-stream output.
// A start command captures cfg_len sample pairs into a pair FIFO; each pair is
// serialized as an A beat then a B beat (enabled channels only), tagged with
// channel and overrange, with tlast on the final beat of the frame.
// Ports:
//   aclk, areset                  : clock, asynchronous active-high reset
//   cfg_start/abort/len/ch_en     : frame control from the register file
//   adc_valid/data_a/data_b/or    : ADC sample pair stream (never stalled)
//   m_axis_*                      : serialized output stream
//   busy/done/aborted             : frame status
//   overrun/ovr_cnt/cfg_err       : sticky error status, cleared on accepted start
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [1:0]            cfg_ch_en,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data_a,
  input  logic [DATA_WIDTH-1:0] adc_data_b,
  input  logic                  adc_or,
  output logic [DATA_WIDTH+1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  overrun,
  output logic [15:0]           ovr_cnt,
  output logic                  cfg_err
);

  localparam int unsigned PAIR_W = 2 * DATA_WIDTH + 1;
  localparam int unsigned TD_W   = DATA_WIDTH + 2;
  localparam int unsigned TD_CH  = tdata_ch_idx(DATA_WIDTH);
  localparam int unsigned TD_OR  = tdata_or_idx(DATA_WIDTH);
  localparam int unsigned P_OR   = pair_or_idx(DATA_WIDTH);
  localparam int unsigned P_A    = pair_a_lsb(DATA_WIDTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_acc_cnt;
  logic [LEN_WIDTH-1:0]  r_out_cnt;
  logic [1:0]            r_ch_en;
  logic                  r_half;
  logic [TD_W-1:0]       r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_aborted;
  logic                  r_overrun;
  logic [15:0]           r_ovr_cnt;
  logic                  r_cfg_err;

  logic                  w_start_ok;
  logic                  w_start_acc;
  logic                  w_start_bad;
  logic                  w_cap_in;
  logic                  w_wr;
  logic                  w_drop;
  logic                  w_flush;
  logic                  w_hs;
  logic                  w_load;
  logic                  w_rd;
  logic                  w_beat_is_b;
  logic                  w_beat_pops;
  logic                  w_beat_tlast;
  logic [TD_W-1:0]       w_beat;
  logic                  w_done_set;
  logic                  w_abort_fin;
  logic [PAIR_W-1:0]     w_wr_pair;
  logic [PAIR_W-1:0]     w_head;
  logic                  w_full;
  logic                  w_empty;

  assign w_start_ok  = cfg_start && (cfg_len != '0) && (cfg_ch_en != 2'b00);
  assign w_start_acc = (r_state == ST_IDLE) && w_start_ok;
  assign w_start_bad = (r_state == ST_IDLE) && cfg_start && !w_start_ok;

  // ADC side: an abort in the same cycle already blocks the write
  assign w_cap_in  = (r_state == ST_CAPTURE) && !cfg_abort && adc_valid;
  assign w_wr      = w_cap_in && !w_full;
  assign w_drop    = w_cap_in && w_full;
  assign w_wr_pair = {adc_or, adc_data_a, adc_data_b};
  assign w_flush   = (r_state == ST_ABORT);

  // Serializer: with both channels on, the head entry is popped only on its B beat
  assign w_hs         = r_tvalid && m_axis_tready;
  assign w_load       = ((r_state == ST_CAPTURE) || (r_state == ST_DRAIN)) && !cfg_abort &&
                        !w_empty && (!r_tvalid || m_axis_tready);
  assign w_beat_is_b  = (r_ch_en == 2'b10) || ((r_ch_en == 2'b11) && r_half);
  assign w_beat_pops  = (r_ch_en != 2'b11) || r_half;
  assign w_beat_tlast = w_beat_pops && (r_out_cnt == r_len - LEN_WIDTH'(1));
  assign w_rd         = w_load && w_beat_pops;

  // Beat formatting from the FIFO head
  always_comb begin
    w_beat                   = '0;
    w_beat[TD_CH]            = w_beat_is_b ? CH_B : CH_A;
    w_beat[TD_OR]            = w_head[P_OR];
    w_beat[DATA_WIDTH-1:0]   = w_beat_is_b ? w_head[DATA_WIDTH-1:0]
                                           : w_head[P_A +: DATA_WIDTH];
  end

  adc_pair_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (aclk),
    .i_rst       (areset),
    .i_flush     (w_flush),
    .i_wr_en     (w_wr),
    .i_wr_data   (w_wr_pair),
    .i_rd_en     (w_rd),
    .o_rd_data_c (w_head),
    .o_full_c    (w_full),
    .o_empty_c   (w_empty)
  );

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and completion pulses
  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    w_abort_fin = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cfg_abort)
          w_state_nxt = ST_ABORT;
        else if (w_wr && (r_acc_cnt == r_len - LEN_WIDTH'(1)))
          w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cfg_abort) begin
          w_state_nxt = ST_ABORT;
        end else if (w_hs && r_tlast) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end
      end
      ST_ABORT: begin
        // Leave once any beat already on the bus has been taken
        if (!r_tvalid || m_axis_tready) begin
          w_state_nxt = ST_IDLE;
          w_abort_fin = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame configuration and sample counters
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_len     <= '0;
      r_ch_en   <= '0;
      r_acc_cnt <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_start_acc) begin
        r_len     <= cfg_len;
        r_ch_en   <= cfg_ch_en;
        r_acc_cnt <= '0;
        r_out_cnt <= '0;
      end
      if (w_wr) r_acc_cnt <= r_acc_cnt + LEN_WIDTH'(1);
      if (w_rd) r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
    end
  end

  // Output beat register; held stable while valid and not ready
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_half   <= 1'b0;
    end else if (w_start_acc || w_flush) begin
      r_half <= 1'b0;
      if (w_hs) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_beat;
      r_tlast  <= w_beat_tlast;
      r_half   <= !w_beat_pops;
    end else if (w_hs) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  // Status flags
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_overrun <= 1'b0;
      r_ovr_cnt <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_set;
      r_aborted <= w_abort_fin;
      if (w_start_acc) begin
        r_overrun <= 1'b0;
        r_ovr_cnt <= '0;
        r_cfg_err <= 1'b0;
      end else if (w_start_bad) begin
        r_cfg_err <= 1'b1;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
        if (r_ovr_cnt != 16'hFFFF) r_ovr_cnt <= r_ovr_cnt + 16'd1;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign busy          = r_busy;
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign overrun       = r_overrun;
  assign ovr_cnt       = r_ovr_cnt;
  assign cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: directed frames plus randomized
// frames, compared beat-by-beat against a frame-level reference model.
module tb_adc_capture_ctrl;

  localparam int unsigned DW = 14;
  localparam int unsigned LW = 16;
  localparam int unsigned FD = 16;
  localparam int unsigned TW = DW + 2;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [1:0]    cfg_ch_en = '0;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] adc_data_a = '0;
  logic [DW-1:0] adc_data_b = '0;
  logic          adc_or = 1'b0;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          busy, done, aborted, overrun, cfg_err;
  logic [15:0]   ovr_cnt;

  adc_capture_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
    .aclk(aclk), .areset(areset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_len(cfg_len), .cfg_ch_en(cfg_ch_en), .adc_valid(adc_valid),
    .adc_data_a(adc_data_a), .adc_data_b(adc_data_b), .adc_or(adc_or),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .aborted(aborted), .overrun(overrun),
    .ovr_cnt(ovr_cnt), .cfg_err(cfg_err)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic rand_ready = 1'b0;

  // Observed beats {tlast, tdata}, expected beats, and accepted pairs
  logic [TW:0]   got_q[$];
  logic [TW:0]   exp_q[$];
  logic [DW-1:0] pa[$];
  logic [DW-1:0] pb[$];
  logic          po[$];
  int first_tv_cyc = -1, last_hs_cyc = -1, done_cnt = 0, done_cyc = -1, ab_cnt = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  // Bus monitor, sampled mid-cycle
  always @(negedge aclk) begin
    if (!areset) begin
      if (m_axis_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back({m_axis_tlast, m_axis_tdata});
        last_hs_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (aborted) ab_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference beat: {tlast, channel, overrange, sample}
  function automatic logic [TW:0] mk(input logic last, input logic ch, input logic orr,
                                     input logic [DW-1:0] s);
    return {last, ch, orr, s};
  endfunction

  // Frame model: A then B per accepted pair, tlast on last enabled beat of pair len-1
  task automatic build_expected(input int len, input logic [1:0] en);
    exp_q.delete();
    for (int i = 0; i < pa.size(); i++) begin
      if (en[0]) exp_q.push_back(mk((i == len - 1) && !en[1], 1'b0, po[i], pa[i]));
      if (en[1]) exp_q.push_back(mk(i == len - 1, 1'b1, po[i], pb[i]));
    end
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_nbeats"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_mon();
    got_q.delete(); pa.delete(); pb.delete(); po.delete();
    first_tv_cyc = -1; last_hs_cyc = -1; done_cnt = 0; done_cyc = -1; ab_cnt = 0;
  endtask

  task automatic start_cmd(input int len, input logic [1:0] en);
    cfg_start = 1'b1; cfg_len = LW'(len); cfg_ch_en = en;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic orr,
                      input bit accepted);
    adc_valid = 1'b1; adc_data_a = a; adc_data_b = b; adc_or = orr;
    if (accepted) begin pa.push_back(a); pb.push_back(b); po.push_back(orr); end
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (done_cnt != 0) break;
      tick();
    end
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int v_cyc;
    int len;
    logic [1:0] en;

    // Reset state
    idle(3);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    areset = 1'b0;
    tick();
    chk("rst_status", {26'd0, done, aborted, overrun, cfg_err, m_axis_tlast, busy}, 32'd0);
    chk("rst_ovr_cnt", 32'(ovr_cnt), 32'd0);

    // 1: both channels, valid every other cycle
    clear_mon();
    start_cmd(4, 2'b11);
    for (int i = 0; i < 4; i++) begin
      send(DW'(14'h0010 + i), DW'(14'h2000 + i), 1'b0, 1'b1);
      tick();
    end
    wait_done("t1", 100);
    build_expected(4, 2'b11);
    compare_stream("t1");
    chk("t1_done_lat", 32'(done_cyc), 32'(last_hs_cyc + 1));
    chk("t1_overrun", 32'(overrun), 32'd0);
    idle(3);
    chk("t1_done_once", 32'(done_cnt), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);

    // 2: channel A only, continuous valid, latency
    clear_mon();
    start_cmd(3, 2'b01);
    v_cyc = cyc;
    for (int i = 0; i < 3; i++) send(DW'(14'h0010 + i), DW'(14'h2000 + i), 1'b0, 1'b1);
    wait_done("t2", 100);
    build_expected(3, 2'b01);
    compare_stream("t2");
    chk("t2_first_tvalid", 32'(first_tv_cyc), 32'(v_cyc + 2));
    chk("t2_overrun", 32'(overrun), 32'd0);

    // 3: overrun with tready low, then recovery to a full 80-beat frame
    clear_mon();
    m_axis_tready = 1'b0;
    start_cmd(40, 2'b11);
    for (int i = 0; i < 30; i++)
      send(DW'($urandom_range(0, 16383)), DW'($urandom_range(0, 16383)), 1'b0, i < 16);
    chk("t3_overrun", 32'(overrun), 32'd1);
    chk("t3_ovr_cnt", 32'(ovr_cnt), 32'd14);
    m_axis_tready = 1'b1;
    idle(40);
    for (int i = 0; i < 24; i++) begin
      send(DW'($urandom_range(0, 16383)), DW'($urandom_range(0, 16383)), 1'b0, 1'b1);
      tick();
    end
    wait_done("t3", 200);
    build_expected(40, 2'b11);
    compare_stream("t3");
    chk("t3_ovr_cnt_end", 32'(ovr_cnt), 32'd14);

    // 4: abort during capture with a beat stalled on the bus
    clear_mon();
    m_axis_tready = 1'b0;
    start_cmd(10, 2'b11);
    for (int i = 0; i < 3; i++) begin
      send(DW'(14'h0100 + i), DW'(14'h0200 + i), 1'b0, 1'b1);
      tick();
    end
    chk("t4_tvalid_pre", 32'(m_axis_tvalid), 32'd1);
    chk("t4_tdata_pre", 32'(m_axis_tdata), 32'(mk(1'b0, 1'b0, 1'b0, pa[0])));
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    idle(3);
    chk("t4_tdata_held", 32'(m_axis_tdata), 32'(mk(1'b0, 1'b0, 1'b0, pa[0])));
    chk("t4_tvalid_held", 32'(m_axis_tvalid), 32'd1);
    chk("t4_busy_held", 32'(busy), 32'd1);
    m_axis_tready = 1'b1;
    for (int k = 0; k < 20 && ab_cnt == 0; k++) tick();
    idle(4);
    chk("t4_nbeats", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("t4_beat", 32'(got_q[0]), 32'(mk(1'b0, 1'b0, 1'b0, pa[0])));
    chk("t4_aborted", 32'(ab_cnt), 32'd1);
    chk("t4_no_done", 32'(done_cnt), 32'd0);
    chk("t4_tvalid_end", 32'(m_axis_tvalid), 32'd0);
    chk("t4_busy_end", 32'(busy), 32'd0);

    // 5: overrange on sample 2 only
    clear_mon();
    start_cmd(4, 2'b11);
    for (int i = 0; i < 4; i++) begin
      send(DW'(14'h0010 + i), DW'(14'h2000 + i), i == 2, 1'b1);
      tick();
    end
    wait_done("t5", 100);
    build_expected(4, 2'b11);
    compare_stream("t5");
    if (got_q.size() >= 6) begin
      chk("t5_beat4", 32'(got_q[3]), 32'h0A001);
      chk("t5_beat5", 32'(got_q[4]), 32'h04012);
      chk("t5_beat6", 32'(got_q[5]), 32'h0E002);
    end

    // 6a: rejected starts, then start while busy is ignored
    clear_mon();
    start_cmd(0, 2'b11);
    tick();
    chk("t6_cfg_err_len0", 32'(cfg_err), 32'd1);
    chk("t6_busy_len0", 32'(busy), 32'd0);
    start_cmd(5, 2'b00);
    tick();
    chk("t6_cfg_err_en0", 32'(cfg_err), 32'd1);
    chk("t6_busy_en0", 32'(busy), 32'd0);
    start_cmd(3, 2'b01);
    chk("t6_cfg_err_clr", 32'(cfg_err), 32'd0);
    send(DW'(14'h0300), DW'(14'h0400), 1'b0, 1'b1);
    cfg_start = 1'b1; cfg_len = LW'(7); cfg_ch_en = 2'b11;
    send(DW'(14'h0301), DW'(14'h0401), 1'b0, 1'b1);
    cfg_start = 1'b0;
    send(DW'(14'h0302), DW'(14'h0402), 1'b0, 1'b1);
    wait_done("t6a", 100);
    build_expected(3, 2'b01);
    compare_stream("t6a");
    chk("t6a_cfg_err", 32'(cfg_err), 32'd0);

    // 6b: overrun, enter DRAIN with a stalled beat, then async reset
    clear_mon();
    m_axis_tready = 1'b0;
    start_cmd(18, 2'b01);
    for (int i = 0; i < 20; i++) send(DW'(i), DW'(0), 1'b0, i < 17);
    chk("t6b_ovr_cnt", 32'(ovr_cnt), 32'd3);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    send(DW'(14'h3FFF), DW'(0), 1'b0, 1'b1);
    idle(2);
    chk("t6b_busy", 32'(busy), 32'd1);
    chk("t6b_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("t6b_one_beat", 32'(got_q.size()), 32'd1);
    #2;
    areset = 1'b1;
    #1;
    chk("t6b_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t6b_rst_status", {26'd0, done, aborted, overrun, cfg_err, m_axis_tlast, busy}, 32'd0);
    chk("t6b_rst_ovr_cnt", 32'(ovr_cnt), 32'd0);
    chk("t6b_rst_tdata", 32'(m_axis_tdata), 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    clear_mon();
    start_cmd(2, 2'b11);
    for (int i = 0; i < 2; i++) begin
      send(DW'(14'h0050 + i), DW'(14'h0060 + i), 1'b0, 1'b1);
      tick();
    end
    wait_done("t6c", 100);
    build_expected(2, 2'b11);
    compare_stream("t6c");

    // Randomized frames with random backpressure and rate-limited input
    for (int f = 0; f < 8; f++) begin
      clear_mon();
      len = $urandom_range(1, 12);
      en = 2'($urandom_range(1, 3));
      rand_ready = 1'b1;
      start_cmd(len, en);
      for (int i = 0; i < len; i++) begin
        send(DW'($urandom_range(0, 16383)), DW'($urandom_range(0, 16383)),
             $urandom_range(0, 3) == 0, 1'b1);
        idle($urandom_range(5, 8));
      end
      wait_done($sformatf("rnd%0d", f), 400);
      rand_ready = 1'b0;
      m_axis_tready = 1'b1;
      build_expected(len, en);
      compare_stream($sformatf("rnd%0d", f));
      chk($sformatf("rnd%0d_overrun", f), 32'(overrun), 32'd0);
      idle(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
